// File: rtl/axi_stream_arb_pkg.sv
// Shared types and constants for the AXI channel stream arbiter.
// Channel indices follow the converter's AR/AW/R/W/B ordering.
package axi_stream_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int CH_AR = 0;
    localparam int CH_AW = 1;
    localparam int CH_R  = 2;
    localparam int CH_W  = 3;
    localparam int CH_B  = 4;

    // (base + off) mod n, assuming base < n and off < n
    function automatic int rr_wrap(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: first set request at or after i_ptr,
// wrapping around; returns one-hot grant, its index and whether anything was set.
module rr_priority_picker
    import axi_stream_arb_pkg::*;
#(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [N-1:0] w_bit;

    // Walk from the farthest offset back to i_ptr so the nearest request wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_bit   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_bit = N'(1) << rr_wrap(int'(i_ptr), k, N);
            if ((i_req & w_bit) != '0) begin
                o_grant = w_bit;
                o_idx   = IDX_W'(rr_wrap(int'(i_ptr), k, N));
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_channel_stream_arbiter.sv
// Packet-granular round-robin merge of the AR/AW/R/W/B streams onto one
// registered AXI-Stream output, tagging each beat with its source channel.
module axi_channel_stream_arbiter
    import axi_stream_arb_pkg::*;
#(
    parameter int CHANNELS = 5,
    parameter int DATA_W   = 64,
    parameter int ID_W     = 3,
    parameter int CNT_W    = 16
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [CHANNELS*DATA_W-1:0]   s_tdata,
    input  logic [CHANNELS-1:0]          s_tvalid,
    input  logic [CHANNELS-1:0]          s_tlast,
    output logic [CHANNELS-1:0]          s_tready,
    input  logic [CHANNELS-1:0]          ch_enable,
    output logic [DATA_W-1:0]            m_tdata,
    output logic                         m_tvalid,
    output logic                         m_tlast,
    output logic [ID_W-1:0]              m_tid,
    input  logic                         m_tready,
    output logic                         busy,
    output logic [CNT_W-1:0]             pkt_count
);

    arb_state_t          r_state;
    logic [ID_W-1:0]     r_grant;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [DATA_W-1:0]   r_m_tdata;
    logic                r_m_tvalid;
    logic                r_m_tlast;
    logic [ID_W-1:0]     r_m_tid;
    logic [CNT_W-1:0]    r_pkt_cnt;

    logic [CHANNELS-1:0] w_pick_oh;
    logic [ID_W-1:0]     w_pick_idx;
    logic                w_pick_any;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_sel_last;
    logic                w_sel_valid;
    logic                w_out_free;
    logic                w_src_hs;
    logic                w_out_hs;
    logic [ID_W-1:0]     w_next_ptr;

    rr_priority_picker #(
        .N     (CHANNELS),
        .IDX_W (ID_W)
    ) u_picker (
        .i_req   (s_tvalid & ch_enable),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_comb begin
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_grant == ID_W'(i)) begin
                w_sel_data  = s_tdata[i*DATA_W +: DATA_W];
                w_sel_last  = s_tlast[i];
                w_sel_valid = s_tvalid[i];
            end
        end
    end

    // Ready is a function of state and output occupancy only, never of s_tvalid.
    assign w_out_free = !r_m_tvalid || m_tready;
    assign s_tready   = (r_state == LOCKED && w_out_free) ? (CHANNELS'(1) << r_grant) : '0;
    assign w_src_hs   = (r_state == LOCKED) && w_out_free && w_sel_valid;
    assign w_out_hs   = r_m_tvalid && m_tready;
    assign w_next_ptr = (r_grant == ID_W'(CHANNELS - 1)) ? '0 : r_grant + 1'b1;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant <= w_pick_idx;
                        r_state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_src_hs && w_sel_last) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tid    <= '0;
        end else if (w_src_hs) begin
            r_m_tdata  <= w_sel_data;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= w_sel_last;
            r_m_tid    <= r_grant;
        end else if (w_out_hs) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            r_pkt_cnt <= '0;
        else if (w_out_hs && r_m_tlast)
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end

    assign m_tdata   = r_m_tdata;
    assign m_tvalid  = r_m_tvalid;
    assign m_tlast   = r_m_tlast;
    assign m_tid     = r_m_tid;
    assign busy      = (r_state == LOCKED);
    assign pkt_count = r_pkt_cnt;

endmodule

// File: tb/tb_axi_channel_stream_arbiter.sv
// Directed bench for the channel stream arbiter: queue-fed sources, an output
// beat recorder, and one task per scenario with hand-computed expectations.
module tb_axi_channel_stream_arbiter;
    import axi_stream_arb_pkg::*;

    localparam int CH = 5;
    localparam int DW = 64;
    localparam int IW = 3;
    localparam int CW = 4;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [CH*DW-1:0]  s_tdata = '0;
    logic [CH-1:0]     s_tvalid = '0;
    logic [CH-1:0]     s_tlast = '0;
    logic [CH-1:0]     s_tready;
    logic [CH-1:0]     ch_enable = '1;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic [IW-1:0]     m_tid;
    logic              m_tready = 1'b1;
    logic              busy;
    logic [CW-1:0]     pkt_count;

    axi_channel_stream_arbiter #(
        .CHANNELS (CH), .DATA_W (DW), .ID_W (IW), .CNT_W (CW)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .ch_enable (ch_enable),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tid     (m_tid),
        .m_tready  (m_tready),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 aclk = ~aclk;

    typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { logic [IW-1:0] tid; logic [DW-1:0] data; logic last; int cyc; } obs_t;

    beat_t         src_q [CH][$];
    obs_t          cap[$];
    int            cyc = 0;
    logic [CH-1:0] hs_n = '0;
    int            tests = 0;
    int            failed = 0;

    function automatic logic [DW-1:0] mk(input int ch, input int p, input int b);
        return (64'(ch) << 16) | (64'(p) << 8) | 64'(b);
    endfunction

    // Inputs are stable from posedge+1 through the next posedge, so the
    // negedge view of handshakes is what the DUT sees at the edge.
    always @(negedge aclk) begin
        hs_n = s_tvalid & s_tready;
        if (m_tvalid && m_tready && !areset)
            cap.push_back('{tid: m_tid, data: m_tdata, last: m_tlast, cyc: cyc});
    end

    always @(posedge aclk) begin
        cyc = cyc + 1;
        #1;
        for (int i = 0; i < CH; i++) begin
            if (hs_n[i] && src_q[i].size() > 0) src_q[i].delete(0);
            if (src_q[i].size() > 0) begin
                s_tvalid[i]             = 1'b1;
                s_tdata[i*DW +: DW]     = src_q[i][0].data;
                s_tlast[i]              = src_q[i][0].last;
            end else begin
                s_tvalid[i]             = 1'b0;
                s_tdata[i*DW +: DW]     = '0;
                s_tlast[i]              = 1'b0;
            end
        end
        hs_n = '0;
    end

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        m_tready = 1'b1;
        ch_enable = '1;
        for (int i = 0; i < CH; i++) src_q[i].delete();
        @(negedge aclk);
        cap.delete();
        areset = 1'b0;
        @(posedge aclk); #2;
    endtask

    task automatic push_pkt(input int ch, input int p, input int beats);
        for (int b = 0; b < beats; b++)
            src_q[ch].push_back('{data: mk(ch, p, b), last: (b == beats - 1)});
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int k = 0; k < budget && cap.size() < n; k++) begin
            @(posedge aclk); #2;
        end
    endtask

    task automatic test_reset();
        @(negedge aclk); #1;
        tests++; if (m_tvalid !== 1'b0) begin failed++; $display("FAIL reset_m_tvalid: got %0b want 0", m_tvalid); end
        tests++; if (m_tlast !== 1'b0) begin failed++; $display("FAIL reset_m_tlast: got %0b want 0", m_tlast); end
        tests++; if (m_tdata !== '0) begin failed++; $display("FAIL reset_m_tdata: got %0h want 0", m_tdata); end
        tests++; if (m_tid !== '0) begin failed++; $display("FAIL reset_m_tid: got %0d want 0", m_tid); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
        tests++; if (s_tready !== '0) begin failed++; $display("FAIL reset_s_tready: got %b want 0", s_tready); end
        tests++; if (pkt_count !== '0) begin failed++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
        do_reset();
    endtask

    // Request visible at k=0; beats on the output at k=2..5.
    task automatic test_single();
        do_reset();
        push_pkt(CH_R, 0, 4);
        for (int k = 0; k < 8; k++) begin
            @(posedge aclk); #2;
            tests++;
            if (m_tvalid !== (k >= 2 && k <= 5)) begin
                failed++; $display("FAIL single_tvalid k=%0d: got %0b want %0b", k, m_tvalid, (k >= 2 && k <= 5));
            end
            if (k >= 2 && k <= 5) begin
                tests++;
                if (m_tid !== 3'd2 || m_tdata !== mk(2, 0, k - 2) || m_tlast !== (k == 5)) begin
                    failed++; $display("FAIL single_beat k=%0d: got id=%0d d=%0h l=%0b want id=2 d=%0h l=%0b",
                                       k, m_tid, m_tdata, m_tlast, mk(2, 0, k - 2), (k == 5));
                end
            end
            if (k >= 1 && k <= 5) begin
                tests++;
                if (busy !== (k <= 4)) begin failed++; $display("FAIL single_busy k=%0d: got %0b want %0b", k, busy, (k <= 4)); end
            end
        end
        tests++; if (pkt_count !== 4'd1) begin failed++; $display("FAIL single_pkt_count: got %0d want 1", pkt_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        push_pkt(CH_W, 0, 4);
        repeat (4) @(posedge aclk);
        #2;
        m_tready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge aclk);
            tests++;
            if (m_tvalid !== 1'b1 || m_tdata !== mk(3, 0, 1) || s_tready[3] !== 1'b0) begin
                failed++; $display("FAIL stall_hold s=%0d: got v=%0b d=%0h rdy=%0b want v=1 d=%0h rdy=0",
                                   s, m_tvalid, m_tdata, s_tready[3], mk(3, 0, 1));
            end
            @(posedge aclk); #2;
        end
        m_tready = 1'b1;
        wait_beats(4, 20);
        repeat (5) @(posedge aclk);
        #2;
        tests++; if (cap.size() != 4) begin failed++; $display("FAIL stall_beat_count: got %0d want 4", cap.size()); end
        for (int b = 0; b < 4 && b < cap.size(); b++) begin
            tests++;
            if (cap[b].tid !== 3'd3 || cap[b].data !== mk(3, 0, b) || cap[b].last !== (b == 3)) begin
                failed++; $display("FAIL stall_beat b=%0d: got id=%0d d=%0h want id=3 d=%0h", b, cap[b].tid, cap[b].data, mk(3, 0, b));
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < CH; c++) push_pkt(c, p, 2);
        wait_beats(20, 100);
        tests++; if (cap.size() != 20) begin failed++; $display("FAIL fair_beat_count: got %0d want 20", cap.size()); end
        for (int k = 0; k < 20 && k < cap.size(); k++) begin
            tests++;
            if (cap[k].tid !== IW'((k / 2) % 5) || cap[k].data !== mk((k / 2) % 5, k / 10, k % 2) || cap[k].last !== (k % 2 == 1)) begin
                failed++; $display("FAIL fair_order k=%0d: got id=%0d d=%0h want id=%0d d=%0h",
                                   k, cap[k].tid, cap[k].data, (k / 2) % 5, mk((k / 2) % 5, k / 10, k % 2));
            end
            if (k > 0) begin
                tests++;
                if (cap[k].cyc - cap[k-1].cyc != ((k % 2 == 0) ? 2 : 1)) begin
                    failed++; $display("FAIL fair_spacing k=%0d: got %0d want %0d", k, cap[k].cyc - cap[k-1].cyc, (k % 2 == 0) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_enable_mask();
        int exp_id [10] = '{0, 0, 1, 1, 1, 1, 3, 3, 4, 4};
        int exp_b  [10] = '{0, 1, 0, 1, 2, 3, 0, 1, 0, 1};
        bit seen1 = 1'b0;
        do_reset();
        ch_enable = 5'b11011;
        push_pkt(0, 0, 2); push_pkt(1, 0, 4); push_pkt(2, 0, 2); push_pkt(3, 0, 2); push_pkt(4, 0, 2);
        for (int k = 0; k < 30 && !seen1; k++) begin
            @(posedge aclk); #2;
            if (m_tvalid && m_tid == 3'd1) seen1 = 1'b1;
        end
        tests++; if (!seen1) begin failed++; $display("FAIL mask_ch1_start: got no channel-1 beat want one"); end
        ch_enable[1] = 1'b0;
        wait_beats(10, 60);
        repeat (10) @(posedge aclk);
        #2;
        tests++; if (cap.size() != 10) begin failed++; $display("FAIL mask_beat_count: got %0d want 10", cap.size()); end
        for (int k = 0; k < 10 && k < cap.size(); k++) begin
            tests++;
            if (cap[k].tid !== IW'(exp_id[k]) || cap[k].data !== mk(exp_id[k], 0, exp_b[k])) begin
                failed++; $display("FAIL mask_order k=%0d: got id=%0d d=%0h want id=%0d d=%0h",
                                   k, cap[k].tid, cap[k].data, exp_id[k], mk(exp_id[k], 0, exp_b[k]));
            end
        end
        tests++; if (busy !== 1'b0 || s_tvalid[2] !== 1'b1) begin failed++; $display("FAIL mask_ch2_idle: got busy=%0b v2=%0b want busy=0 v2=1", busy, s_tvalid[2]); end
    endtask

    task automatic test_async_reset();
        bit hit = 1'b0;
        do_reset();
        push_pkt(1, 0, 1);
        wait_beats(1, 20);
        push_pkt(2, 0, 4);
        for (int k = 0; k < 30 && !hit; k++) begin
            @(posedge aclk); #2;
            if (m_tvalid && m_tid == 3'd2 && m_tdata == mk(2, 0, 1)) hit = 1'b1;
        end
        tests++; if (!hit) begin failed++; $display("FAIL areset_beat2_seen: got none want beat 2 of channel 2"); end
        @(negedge aclk); #1;
        areset = 1'b1;
        #1;
        tests++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || m_tid !== '0 || busy !== 1'b0 || s_tready !== '0 || pkt_count !== '0) begin
            failed++; $display("FAIL areset_immediate: got v=%0b l=%0b d=%0h id=%0d busy=%0b rdy=%b cnt=%0d want all 0",
                               m_tvalid, m_tlast, m_tdata, m_tid, busy, s_tready, pkt_count);
        end
        for (int i = 0; i < CH; i++) src_q[i].delete();
        @(posedge aclk); #2;
        @(negedge aclk);
        cap.delete();
        areset = 1'b0;
        @(posedge aclk); #2;
        push_pkt(0, 1, 1);
        push_pkt(4, 1, 1);
        wait_beats(2, 20);
        tests++;
        if (cap.size() != 2 || cap[0].tid !== 3'd0 || cap[1].tid !== 3'd4) begin
            failed++; $display("FAIL areset_first_winner: got n=%0d first=%0d want n=2 first=0 second=4",
                               cap.size(), (cap.size() > 0) ? int'(cap[0].tid) : -1);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int p = 0; p < 17; p++) push_pkt(0, p, 1);
        wait_beats(17, 120);
        @(posedge aclk); #2;
        tests++; if (cap.size() != 17) begin failed++; $display("FAIL wrap_beat_count: got %0d want 17", cap.size()); end
        tests++; if (pkt_count !== 4'd1) begin failed++; $display("FAIL wrap_pkt_count: got %0d want 1", pkt_count); end
        for (int k = 1; k < 17 && k < cap.size(); k++) begin
            tests++;
            if (cap[k].cyc - cap[k-1].cyc != 2 || cap[k].last !== 1'b1) begin
                failed++; $display("FAIL wrap_single_beat_spacing k=%0d: got %0d want 2", k, cap[k].cyc - cap[k-1].cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_fairness();
        test_enable_mask();
        test_async_reset();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/axi_channel_stream_arbiter.md
# axi_channel_stream_arbiter

Packet-granular round-robin arbiter that merges the five per-channel AXI-Stream sources (AR, AW, R, W, B) of the AXI-to-stream converter onto its single AXI-Stream output. Each forwarded beat carries a channel tag in `m_tid`. A grant holds until the granted source's `tlast` beat is accepted, so packets never interleave. A software enable mask excludes channels from arbitration.

## Interface
Parameters:
- `CHANNELS`, 5: number of source channels; index 0..4 = AR, AW, R, W, B.
- `DATA_W`, 64: tdata width per channel.
- `ID_W`, 3: width of `m_tid`; must satisfy 2^ID_W ≥ CHANNELS.
- `CNT_W`, 16: width of the packet counter.

Ports:
- `aclk`  in  1  clock; all logic on the rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `s_tdata`  in  CHANNELS*DATA_W  source data; channel i occupies bits [i*DATA_W +: DATA_W].
- `s_tvalid`  in  CHANNELS  source valid.
- `s_tlast`  in  CHANNELS  source end of packet.
- `s_tready`  out  CHANNELS  source ready.
- `ch_enable`  in  CHANNELS  per-channel arbitration enable; quasi-static.
- `m_tdata`  out  DATA_W  merged data, registered.
- `m_tvalid`  out  1  merged valid, registered.
- `m_tlast`  out  1  merged end of packet, registered.
- `m_tid`  out  ID_W  index of the originating channel, registered.
- `m_tready`  in  1  downstream ready.
- `busy`  out  1  high while in LOCKED.
- `pkt_count`  out  CNT_W  count of packets completed on the output; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE and LOCKED.
- IDLE:
  - Eligible channels are those with `s_tvalid[i] & ch_enable[i]`.
  - If any channel is eligible, select the first one in rotating order starting at `rr_ptr`, register it in `grant`, and go to LOCKED.
  - If no channel is eligible, stay in IDLE.
  - All `s_tready` are 0 in IDLE.
- LOCKED:
  - `s_tready[grant] = !m_tvalid | m_tready`; every other `s_tready` is 0.
  - On a source handshake, load `m_tdata`/`m_tlast`/`m_tid`←`grant` and set `m_tvalid`.
  - On the source handshake with `s_tlast[grant]=1`: go to IDLE and set `rr_ptr ← (grant+1) mod CHANNELS`.
- The output register holds its contents while `m_tvalid & !m_tready`.
- `m_tvalid` clears on an output handshake that has no new source handshake in the same cycle.
- `pkt_count` increments on each output handshake with `m_tlast=1`.
- Deasserting `ch_enable[grant]` mid-packet has no effect; the packet completes. Enables are sampled only in IDLE.
- A source that drops `s_tvalid` mid-packet is waited on indefinitely. There is no timeout.
- Reset in any state:
  - state←IDLE, `grant`←0, `rr_ptr`←0.
  - `m_tvalid`, `m_tlast`, `busy` ← 0; `m_tdata`, `m_tid`, `pkt_count` ← 0.
  - All `s_tready` ← 0.
  - A partially transferred packet is discarded; there is no recovery of it.

## Timing
- Arbitration latency:
  - An eligible request seen in IDLE at cycle n gives LOCKED and `s_tready[grant]` in cycle n+1.
  - The first beat appears on `m_tvalid` in cycle n+2.
- Throughput within a packet is one beat per cycle while `m_tready` is held high.
- There is exactly one idle cycle between consecutive packets (the IDLE arbitration cycle).
- `s_tready` is combinational from `m_tvalid`, `m_tready` and state only. It never depends on `s_tvalid`.
- Simultaneous requests resolve by rotating priority. With `rr_ptr`=3 and channels 0 and 4 both eligible, channel 4 wins.
- Single-beat packet (`tlast` on the first beat): LOCKED lasts one cycle when `m_tready` is high.

## Structure
- Package `axi_stream_arb_pkg`:
  - state enum `arb_state_t` {IDLE, LOCKED};
  - channel index constants `CH_AR`=0, `CH_AW`=1, `CH_R`=2, `CH_W`=3, `CH_B`=4.
- Sub-module `rr_priority_picker`:
  - purely combinational;
  - inputs: request vector and `rr_ptr`;
  - outputs: one-hot grant, encoded index, `any`.
- The arbiter top holds the FSM, the output register and the counter.

## Test plan
- **Single source.** Channel 2 sends a 4-beat packet (tlast on beat 4), `m_tready`=1.
  - m_tvalid rises 2 cycles after s_tvalid, then 4 consecutive beats, all with m_tid=2.
  - m_tlast on beat 4; pkt_count=1; busy falls the following cycle.
- **Fairness.** All five channels continuously send 2-beat packets.
  - m_tid sequence is 0,1,2,3,4,0,… with one bubble between packets.
- **Backpressure.** `m_tready` is held low for 3 cycles mid-packet.
  - m_tdata is stable and s_tready[grant]=0 during the stall; no beat is lost or duplicated.
- **Enable mask.** Set ch_enable=5'b11011 with all channels requesting.
  - Channel 2 is never granted.
  - Clearing ch_enable[1] during a channel-1 packet lets that packet complete.
- **Async reset mid-packet.** Assert areset between clock edges during beat 2 of 4.
  - All outputs go to their reset values immediately.
  - After release, rr_ptr=0 and channel 0 wins the first arbitration.
- **Counter wrap.** With CNT_W=4, send 17 packets.
  - pkt_count reads 1.
